// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - iterative one-bit-per-cycle SLL/SRL/SRA shift unit
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only while idle
//   op         00=SLL, 01=SRL, 10=SRA, 11=pass-through
//   shamt_word shift-mux output; only [4:0] is the shift amount
//   data_in    value to shift
//   busy       high while an operation is in flight (SHIFT or DONE)
//   done       one-cycle pulse, result valid
//   result     last completed result, held until the next completion
module seq_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] shamt_word,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [1:0]       opr;
  logic [4:0]       count;

  // Upper bits of the mux word carry Rs/instruction bits that are meaningless here.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^shamt_word[WIDTH-1:5];

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    state_next = state;
    shifted    = work;
    case (opr)
      2'b00:   shifted = work << 1;
      2'b01:   shifted = work >> 1;
      2'b10:   shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shifted = work;
    endcase
    case (state)
      ST_IDLE: begin
        if (start) begin
          // Zero shift and the reserved op need no iterations at all.
          if (shamt_word[4:0] == 5'd0 || op == 2'b11) state_next = ST_DONE;
          else                                         state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count == 5'd1) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      work   <= '0;
      opr    <= 2'b00;
      count  <= 5'd0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            work  <= data_in;
            opr   <= op;
            count <= shamt_word[4:0];
            if (state_next == ST_DONE) result <= data_in;
          end
        end
        ST_SHIFT: begin
          work  <= shifted;
          count <= count - 5'd1;
          // Final shift and result capture share the same edge.
          if (count == 5'd1) result <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule
